instruction_controller: RTL
===========================

# instruction_controller

Multi-cycle control unit for the 12-bit processor, directly downstream of the instruction register. It owns the program counter that addresses instruction memory, sequences each instruction through fetch, decode and execute, and drives register-file, ALU and data-memory strobes. The instruction register reloads on every `clk` edge, so this block holds `pc` stable for the full life of an instruction so that `instr` stays constant.

## Interface
- `PC_W`, default 8: program counter width; instruction memory depth is 2^PC_W.
- `clk`, input, 1: system clock; all state updates on its rising edge.
- `reset`, input, 1: synchronous, active-high reset.
- `instr`, input, 12: current instruction from the instruction register.
- `alu_zero`, input, 1: ALU result-is-zero flag, valid during EXEC of ADD/SUB.
- `dm_ack`, input, 1: data-memory completion; for LOAD, read data is valid in the same cycle.
- `pc`, output, PC_W: instruction memory address.
- `rf_raddr_a`, output, 3: register-file read port A.
- `rf_raddr_b`, output, 3: register-file read port B.
- `rf_waddr`, output, 3: register-file write address.
- `rf_we`, output, 1: register-file write enable.
- `rf_wsrc`, output, 1: write-data select; 0 selects ALU, 1 selects data memory.
- `alu_sub`, output, 1: 0 means add, 1 means subtract.
- `dm_req`, output, 1: data-memory request.
- `dm_we`, output, 1: data-memory write, qualified by `dm_req`.
- `dm_addr`, output, 6: data-memory address.
- `halted`, output, 1: high once HALT has executed.

## Operation
- Opcode is `instr[11:9]`. Other fields: `rd`/`rs` = `instr[8:6]`, `rs2` = `instr[5:3]`, `rt` = `instr[2:0]`, `addr6` = `instr[5:0]`, `tgt8` = `instr[7:0]`.
- 000 NOP: no side effects.
- 001 LOAD: RF[rd] ← DM[addr6].
- 010 STORE: DM[addr6] ← RF[rs].
- 011 ADD: RF[rd] ← RF[rs2] + RF[rt].
- 100 SUB: RF[rd] ← RF[rs2] − RF[rt].
- 101 JMP: pc ← tgt8.
- 110 JZ: if the zero flag is set, pc ← tgt8; otherwise pc ← pc+1.
- 111 HALT: stop execution.
- State machine:
  - FETCH → DECODE, always.
  - DECODE → EXEC; the opcode and fields are registered at the end of DECODE.
  - EXEC → FETCH, except:
    - LOAD and STORE wait in EXEC until `dm_ack`.
    - HALT goes to HALTED.
  - HALTED is absorbing; only `reset` leaves it.
- PC update happens only on the EXEC→FETCH transition:
  - JMP, and JZ with the flag set: pc ← tgt8.
  - All other instructions: pc ← pc+1, wrapping from 2^PC_W−1 to 0.
- Zero flag is an internal register, updated from `alu_zero` only on the EXEC cycle of ADD/SUB. JZ reads the registered flag, not the live `alu_zero`.
- All strobes are combinational from state and the registered fields, active only in EXEC:
  - ADD/SUB: `rf_we`=1, `rf_wsrc`=0, `alu_sub` = (op==SUB).
  - LOAD: `dm_req`=1, `dm_we`=0. In the `dm_ack` cycle, `rf_we`=1 and `rf_wsrc`=1.
  - STORE: `dm_req`=1, `dm_we`=1, `rf_raddr_a`=rs.
- Outside EXEC, every strobe is 0.

## Timing
- Reset values: `pc`=0, state=FETCH, zero flag=0, `halted`=0. All strobes are 0 in the cycle after reset.
- Latency: non-memory instructions take 3 cycles. LOAD/STORE take 3+N cycles, where N is the number of EXEC cycles without `dm_ack` (N ≥ 0).
- `instr` is captured by the instruction register at the closing edge of FETCH, so it is valid from DECODE onward.
- `pc` is constant from FETCH through EXEC.
- `dm_req` rises on EXEC entry and stays high, with stable `dm_addr` and `dm_we`, until the cycle in which `dm_ack`=1. It falls on the next cycle.
- `dm_ack` is ignored when `dm_req`=0.
- `reset` during a memory wait drops `dm_req` on the next cycle. No partial `rf_we` is issued.
- `halted` rises on the cycle after HALT's EXEC. In HALTED, `pc` holds the HALT address + 1.

## Structure
- Shared package `ctrl_pkg` holds:
  - the opcode enum `opcode_t` (3-bit),
  - the state enum `ctrl_state_t`,
  - field bit-position localparams,
  - `PC_W_DEFAULT`.
- Sub-module `program_counter` implements the PC register, with increment, load-target, hold and synchronous reset.
- The FSM, field registers and zero flag live in the top module.

## Test plan
- Reset, then NOP at 0x00 → `pc` reads 0,0,0 over FETCH/DECODE/EXEC, then 1; no strobes ever asserted.
- ADD `0x6D3` (rd=3, rs2=2, rt=3) with `alu_zero`=1 → `rf_we`=1, `rf_waddr`=3, `alu_sub`=0 for one cycle; a following JZ `0xC40` sets `pc` to 0x40.
- SUB that clears the zero flag (`alu_zero`=0), then JZ `0xC40` → `pc` becomes the JZ address + 1.
- LOAD `0x2A5` (rd=2, addr=0x25) with `dm_ack` delayed 3 cycles → `dm_req` high for 4 cycles at `dm_addr`=0x25, `dm_we`=0; `rf_we`=1 with `rf_wsrc`=1 only in the ack cycle; `pc`+1 afterwards.
- JMP `0xAFF` then NOP at 0xFF → `pc` goes 0xFF, then wraps to 0x00. HALT `0xE00` → `halted`=1, and `pc` is frozen for 10+ cycles.
- STORE waiting on `dm_ack`, then `reset` asserted → `dm_req`=0, `pc`=0 and state FETCH on the following cycle.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared types and field positions for the 12-bit processor control unit.
package ctrl_pkg;

    localparam int unsigned PC_W_DEFAULT = 8;

    typedef enum logic [2:0] {
        OP_NOP   = 3'b000,
        OP_LOAD  = 3'b001,
        OP_STORE = 3'b010,
        OP_ADD   = 3'b011,
        OP_SUB   = 3'b100,
        OP_JMP   = 3'b101,
        OP_JZ    = 3'b110,
        OP_HALT  = 3'b111
    } opcode_t;

    typedef enum logic [1:0] {
        ST_FETCH  = 2'd0,
        ST_DECODE = 2'd1,
        ST_EXEC   = 2'd2,
        ST_HALTED = 2'd3
    } ctrl_state_t;

    // Instruction field bit positions
    localparam int unsigned OP_MSB   = 11;
    localparam int unsigned OP_LSB   = 9;
    localparam int unsigned RD_MSB   = 8;
    localparam int unsigned RD_LSB   = 6;
    localparam int unsigned RS2_MSB  = 5;
    localparam int unsigned RS2_LSB  = 3;
    localparam int unsigned RT_MSB   = 2;
    localparam int unsigned RT_LSB   = 0;
    localparam int unsigned ADDR_MSB = 5;
    localparam int unsigned ADDR_LSB = 0;
    localparam int unsigned TGT_MSB  = 7;
    localparam int unsigned TGT_LSB  = 0;

endpackage

// File: rtl/program_counter.sv
// Program counter register: synchronous reset, load-target, increment (wrapping), hold.
module program_counter
    import ctrl_pkg::*;
#(
    parameter int unsigned PC_W = PC_W_DEFAULT
) (
    input  logic            clk_i,
    input  logic            reset_i,
    input  logic            inc_i,
    input  logic            load_i,
    input  logic [PC_W-1:0] tgt_i,
    output logic [PC_W-1:0] pc_o
);

    logic [PC_W-1:0] pc_q;
    logic [PC_W-1:0] pc_d;

    always_comb begin
        pc_d = pc_q;
        if (load_i) begin
            pc_d = tgt_i;
        end else if (inc_i) begin
            pc_d = pc_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            pc_q <= '0;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o = pc_q;

endmodule

// File: rtl/instruction_controller.sv
// Multi-cycle FETCH/DECODE/EXEC sequencer: owns the PC, registers decoded fields,
// keeps the zero flag and drives register-file, ALU and data-memory strobes.
module instruction_controller
    import ctrl_pkg::*;
#(
    parameter int unsigned PC_W = PC_W_DEFAULT
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [11:0]     instr,
    input  logic            alu_zero,
    input  logic            dm_ack,
    output logic [PC_W-1:0] pc,
    output logic [2:0]      rf_raddr_a,
    output logic [2:0]      rf_raddr_b,
    output logic [2:0]      rf_waddr,
    output logic            rf_we,
    output logic            rf_wsrc,
    output logic            alu_sub,
    output logic            dm_req,
    output logic            dm_we,
    output logic [5:0]      dm_addr,
    output logic            halted
);

    localparam int unsigned TW = (PC_W < 8) ? PC_W : 8;

    ctrl_state_t state_q;
    opcode_t     op_q;
    logic [2:0]  rd_q;
    logic [2:0]  rs2_q;
    logic [2:0]  rt_q;
    logic [5:0]  addr_q;
    logic [7:0]  tgt_q;
    logic        zero_q;
    logic        halted_q;

    logic            in_exec;
    logic            is_mem;
    logic            is_alu;
    logic            leave_exec;
    logic            jump_taken;
    logic [PC_W-1:0] jump_tgt;

    assign in_exec    = (state_q == ST_EXEC);
    assign is_mem     = (op_q == OP_LOAD) || (op_q == OP_STORE);
    assign is_alu     = (op_q == OP_ADD) || (op_q == OP_SUB);
    // Memory ops hold EXEC until acknowledged; everything else leaves after one cycle.
    assign leave_exec = in_exec && (!is_mem || dm_ack);
    assign jump_taken = (op_q == OP_JMP) || ((op_q == OP_JZ) && zero_q);

    always_comb begin
        jump_tgt = '0;
        jump_tgt[TW-1:0] = tgt_q[TW-1:0];
    end

    program_counter #(
        .PC_W (PC_W)
    ) u_pc (
        .clk_i   (clk),
        .reset_i (reset),
        .inc_i   (leave_exec && !jump_taken),
        .load_i  (leave_exec && jump_taken),
        .tgt_i   (jump_tgt),
        .pc_o    (pc)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_FETCH;
            op_q     <= OP_NOP;
            rd_q     <= '0;
            rs2_q    <= '0;
            rt_q     <= '0;
            addr_q   <= '0;
            tgt_q    <= '0;
            zero_q   <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            case (state_q)
                ST_FETCH: begin
                    state_q <= ST_DECODE;
                end
                ST_DECODE: begin
                    state_q <= ST_EXEC;
                    op_q    <= opcode_t'(instr[OP_MSB:OP_LSB]);
                    rd_q    <= instr[RD_MSB:RD_LSB];
                    rs2_q   <= instr[RS2_MSB:RS2_LSB];
                    rt_q    <= instr[RT_MSB:RT_LSB];
                    addr_q  <= instr[ADDR_MSB:ADDR_LSB];
                    tgt_q   <= instr[TGT_MSB:TGT_LSB];
                end
                ST_EXEC: begin
                    if (is_alu) begin
                        zero_q <= alu_zero;
                    end
                    if (leave_exec) begin
                        if (op_q == OP_HALT) begin
                            state_q  <= ST_HALTED;
                            halted_q <= 1'b1;
                        end else begin
                            state_q <= ST_FETCH;
                        end
                    end
                end
                ST_HALTED: begin
                    state_q <= ST_HALTED;
                end
                default: begin
                    state_q <= ST_FETCH;
                end
            endcase
        end
    end

    always_comb begin
        rf_raddr_a = '0;
        rf_raddr_b = '0;
        rf_waddr   = '0;
        rf_we      = 1'b0;
        rf_wsrc    = 1'b0;
        alu_sub    = 1'b0;
        dm_req     = 1'b0;
        dm_we      = 1'b0;
        dm_addr    = '0;
        if (in_exec) begin
            case (op_q)
                OP_ADD, OP_SUB: begin
                    rf_raddr_a = rs2_q;
                    rf_raddr_b = rt_q;
                    rf_waddr   = rd_q;
                    rf_we      = 1'b1;
                    alu_sub    = (op_q == OP_SUB);
                end
                OP_LOAD: begin
                    dm_req   = 1'b1;
                    dm_addr  = addr_q;
                    rf_waddr = rd_q;
                    rf_we    = dm_ack;
                    rf_wsrc  = dm_ack;
                end
                OP_STORE: begin
                    dm_req     = 1'b1;
                    dm_we      = 1'b1;
                    dm_addr    = addr_q;
                    rf_raddr_a = rd_q;
                end
                default: begin
                end
            endcase
        end
    end

    assign halted = halted_q;

endmodule
